// File: rtl/crypto_core_mc.sv
// crypto_core_mc: parametrised multi-cycle core with start/halt run control,
// rotate ops, load-immediate, branch/jump and a ready/ack data-memory port
// that tolerates wait states.
//
// Ports:
//   clk         clock, all state on rising edge
//   reset       synchronous, active-high
//   start       begin execution from IDLE or HALTED (ignored while busy)
//   imem_addr   instruction address (= pc)
//   imem_data   instruction word, combinational from imem_addr
//   dmem_req    data access request, held until dmem_ack
//   dmem_we     1 = store, 0 = load
//   dmem_addr   data address (rs1 + rs2, low ADDR_W bits)
//   dmem_wdata  store data (rd)
//   dmem_rdata  load data, valid in ack cycle
//   dmem_ack    access complete this cycle
//   busy        high in FETCH/EXEC/MEM
//   halted      high in HALTED
//   retired     one-cycle pulse per completed instruction
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | out of reset, waiting for start
// FETCH   | latch instruction word into IR
// EXEC    | execute; ALU/LDI/branch retire, LD/ST go to MEM
// MEM     | data access outstanding, outputs held until ack
// HALTED  | HALT executed, registers kept, start restarts at 0
module crypto_core_mc #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [15:0]       imem_data,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              busy,
    output logic              halted,
    output logic              retired
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_HALTED = 3'd4;

    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_XOR  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_ROL  = 4'h6;
    localparam logic [3:0] OP_ROR  = 4'h7;
    localparam logic [3:0] OP_LD   = 4'h8;
    localparam logic [3:0] OP_ST   = 4'h9;
    localparam logic [3:0] OP_LDI  = 4'hA;
    localparam logic [3:0] OP_BEQZ = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Effective address is formed at DATA_W and widened if the data bus
    // address is wider than the datapath.
    localparam int              EA_W   = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam logic [DATA_W-1:0] DW_VAL = DATA_W'(DATA_W);

    logic [2:0]        state;
    logic [PC_W-1:0]   pc;
    logic [15:0]       ir;
    logic [DATA_W-1:0] regs [16];

    logic [3:0]          op;
    logic [3:0]          rd_idx;
    logic [3:0]          rs1_idx;
    logic [3:0]          rs2_idx;
    logic [7:0]          imm8;
    logic [DATA_W-1:0]   rd_val;
    logic [DATA_W-1:0]   rs1_val;
    logic [DATA_W-1:0]   rs2_val;
    logic [DATA_W-1:0]   rot_amt;
    logic [2*DATA_W-1:0] rot_l;
    logic [2*DATA_W-1:0] rot_r;
    logic [DATA_W-1:0]   alu_res;
    logic [DATA_W-1:0]   imm_ext;
    logic [DATA_W-1:0]   ea_sum;
    logic [EA_W-1:0]     ea_wide;
    logic [PC_W-1:0]     pc_inc;
    logic [PC_W-1:0]     pc_imm;

    assign op      = ir[15:12];
    assign rd_idx  = ir[11:8];
    assign rs1_idx = ir[7:4];
    assign rs2_idx = ir[3:0];
    assign imm8    = ir[7:0];

    assign rd_val  = regs[rd_idx];
    assign rs1_val = regs[rs1_idx];
    assign rs2_val = regs[rs2_idx];

    assign imm_ext = DATA_W'(imm8);
    assign pc_imm  = imm8[PC_W-1:0];
    assign pc_inc  = pc + PC_W'(1);
    assign ea_sum  = rs1_val + rs2_val;
    assign ea_wide = EA_W'(ea_sum);

    assign imem_addr = pc;
    assign busy      = (state == ST_FETCH) || (state == ST_EXEC) || (state == ST_MEM);
    assign halted    = (state == ST_HALTED);

    always_comb begin
        // Rotates use a doubled operand so one shift covers both halves.
        rot_amt = rs2_val % DW_VAL;
        rot_l   = {rs1_val, rs1_val} << rot_amt;
        rot_r   = {rs1_val, rs1_val} >> rot_amt;
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = rs1_val + rs2_val;
            OP_SUB:  alu_res = rs1_val - rs2_val;
            OP_XOR:  alu_res = rs1_val ^ rs2_val;
            OP_AND:  alu_res = rs1_val & rs2_val;
            OP_OR:   alu_res = rs1_val | rs2_val;
            OP_ROL:  alu_res = rot_l[2*DATA_W-1:DATA_W];
            OP_ROR:  alu_res = rot_r[DATA_W-1:0];
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            pc         <= '0;
            ir         <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            retired    <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
        end else begin
            retired <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    ir    <= imem_data;
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    case (op)
                        OP_ADD, OP_SUB, OP_XOR, OP_AND, OP_OR, OP_ROL, OP_ROR: begin
                            regs[rd_idx] <= alu_res;
                            pc           <= pc_inc;
                            retired      <= 1'b1;
                            state        <= ST_FETCH;
                        end
                        OP_LD, OP_ST: begin
                            dmem_addr <= ea_wide[ADDR_W-1:0];
                            dmem_we   <= (op == OP_ST);
                            if (op == OP_ST) begin
                                dmem_wdata <= rd_val;
                            end
                            dmem_req  <= 1'b1;
                            state     <= ST_MEM;
                        end
                        OP_LDI: begin
                            regs[rd_idx] <= imm_ext;
                            pc           <= pc_inc;
                            retired      <= 1'b1;
                            state        <= ST_FETCH;
                        end
                        OP_BEQZ: begin
                            pc      <= (rd_val == '0) ? pc_imm : pc_inc;
                            retired <= 1'b1;
                            state   <= ST_FETCH;
                        end
                        OP_JMP: begin
                            pc      <= pc_imm;
                            retired <= 1'b1;
                            state   <= ST_FETCH;
                        end
                        OP_HALT: begin
                            retired <= 1'b1;
                            state   <= ST_HALTED;
                        end
                        default: begin
                            // NOP and the reserved opcodes D/E
                            pc      <= pc_inc;
                            retired <= 1'b1;
                            state   <= ST_FETCH;
                        end
                    endcase
                end
                ST_MEM: begin
                    if (dmem_ack) begin
                        if (!dmem_we) begin
                            regs[rd_idx] <= dmem_rdata;
                        end
                        dmem_req <= 1'b0;
                        pc       <= pc_inc;
                        retired  <= 1'b1;
                        state    <= ST_FETCH;
                    end
                end
                ST_HALTED: begin
                    if (start) begin
                        pc    <= '0;
                        state <= ST_FETCH;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crypto_core_mc.sv
// Testbench for crypto_core_mc: instruction ROM and a wait-state data memory
// model; completed data accesses and retired pcs are compared against
// expectation queues filled when each program is loaded.
module tb_crypto_core_mc;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] imem_addr;
    logic [15:0] imem_data;
    logic       dmem_req;
    logic       dmem_we;
    logic [7:0] dmem_addr;
    logic [7:0] dmem_wdata;
    logic [7:0] dmem_rdata;
    logic       dmem_ack;
    logic       busy;
    logic       halted;
    logic       retired;

    crypto_core_mc #(.DATA_W(8), .PC_W(8), .ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .start(start),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .busy(busy), .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] cyc;
        logic       stable;
    } txn_t;

    logic [15:0] rom [256];
    logic [7:0]  dmem_model [256];
    assign imem_data = rom[imem_addr];

    int   n_tests = 0;
    int   n_fail  = 0;
    int   wait_cycles = 0;
    bit   hold_ack = 1'b0;
    int   ret_cnt = 0;
    txn_t obs_q[$];
    txn_t exp_q[$];
    logic [7:0] pc_obs_q[$];
    logic [7:0] pc_exp_q[$];

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs1, input logic [3:0] rs2);
        return {op, rd, rs1, rs2};
    endfunction

    function automatic logic [15:0] enci(input logic [3:0] op, input logic [3:0] rd,
                                         input logic [7:0] imm);
        return {op, rd, imm};
    endfunction

    function automatic txn_t mk(input logic we, input logic [7:0] a, input logic [7:0] d,
                                input logic [7:0] c);
        return {we, a, d, c, 1'b1};
    endfunction

    function automatic logic [7:0] alu_model(input logic [3:0] op, input logic [7:0] a,
                                             input logic [7:0] b);
        logic [7:0] r;
        int n;
        r = a;
        n = int'(b) % 8;
        case (op)
            4'h1: r = a + b;
            4'h2: r = a - b;
            4'h3: r = a ^ b;
            4'h4: r = a & b;
            4'h5: r = a | b;
            4'h6: for (int k = 0; k < n; k++) r = {r[6:0], r[7]};
            4'h7: for (int k = 0; k < n; k++) r = {r[0], r[7:1]};
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Data memory responder: acks after wait_cycles extra cycles, records
    // every completed access together with its request length and whether
    // the request outputs stayed stable.
    initial begin : responder
        int cnt;
        logic [7:0] a0;
        logic [7:0] d0;
        logic w0;
        logic st;
        cnt = 0; a0 = '0; d0 = '0; w0 = 1'b0; st = 1'b1;
        dmem_ack = 1'b0;
        dmem_rdata = 8'hEE;
        forever begin
            @(negedge clk);
            if (dmem_req === 1'b1) begin
                if (cnt == 0) begin
                    a0 = dmem_addr; d0 = dmem_wdata; w0 = dmem_we; st = 1'b1;
                end else if (dmem_addr !== a0 || dmem_wdata !== d0 || dmem_we !== w0) begin
                    st = 1'b0;
                end
                cnt++;
                if (!hold_ack && cnt > wait_cycles) begin
                    dmem_ack = 1'b1;
                    if (w0) begin
                        dmem_model[a0] = d0;
                        dmem_rdata = 8'hEE;
                        obs_q.push_back({1'b1, a0, d0, 8'(cnt), st});
                    end else begin
                        dmem_rdata = dmem_model[a0];
                        obs_q.push_back({1'b0, a0, dmem_model[a0], 8'(cnt), st});
                    end
                end else begin
                    dmem_ack = 1'b0;
                    dmem_rdata = ~dmem_model[a0];
                end
            end else begin
                cnt = 0;
                dmem_ack = 1'b0;
                dmem_rdata = 8'hEE;
            end
        end
    end

    initial begin : retire_trace
        forever begin
            @(negedge clk);
            if (retired === 1'b1) begin
                ret_cnt++;
                pc_obs_q.push_back(imem_addr);
            end
        end
    end

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        obs_q.delete(); exp_q.delete();
        pc_obs_q.delete(); pc_exp_q.delete();
        ret_cnt = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts edges after the start edge until halted; one settling cycle is
    // added so the final retire pulse is logged before callers look.
    task automatic wait_halt(input int max, output bit ok, output int cycles);
        ok = 1'b0;
        cycles = 0;
        while (1) begin
            if (halted === 1'b1) begin ok = 1'b1; break; end
            if (cycles >= max) break;
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b expected 0", halted); end
        n_tests++; if (retired !== 1'b0) begin n_fail++; $display("FAIL reset_retired: got %b expected 0", retired); end
        n_tests++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", dmem_req); end
        n_tests++; if (dmem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", dmem_we); end
        n_tests++; if (dmem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %h expected 00", dmem_addr); end
        n_tests++; if (dmem_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_wdata: got %h expected 00", dmem_wdata); end
        n_tests++; if (imem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_pc: got %h expected 00", imem_addr); end
        repeat (4) @(negedge clk);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_no_start: busy got %b expected 0", busy); end
    endtask

    task automatic test_basic();
        bit ok;
        int cyc;
        txn_t e, g;
        wait_cycles = 0; hold_ack = 1'b0;
        do_reset();
        clear_rom();
        rom[0] = enci(4'hA, 4'd1, 8'h3C);
        rom[1] = enci(4'hA, 4'd2, 8'h05);
        rom[2] = enc(4'h1, 4'd3, 4'd1, 4'd2);
        rom[3] = 16'hF000;
        pulse_start();
        wait_halt(60, ok, cyc);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL basic_timeout: halted never seen within %0d cycles", cyc); end
        n_tests++; if (cyc != 8) begin n_fail++; $display("FAIL basic_halt_cycles: got %0d expected 8", cyc); end
        n_tests++; if (ret_cnt != 4) begin n_fail++; $display("FAIL basic_retired: got %0d expected 4", ret_cnt); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy: got %b expected 0", busy); end
        n_tests++; if (imem_addr !== 8'h03) begin n_fail++; $display("FAIL basic_halt_pc: got %h expected 03", imem_addr); end
        // Restart from HALTED with registers kept: expose r3 through a store.
        rom[0] = enc(4'h9, 4'd3, 4'd0, 4'd0);
        rom[1] = 16'hF000;
        exp_q.push_back(mk(1'b1, 8'h00, alu_model(4'h1, 8'h3C, 8'h05), 8'd1));
        ret_cnt = 0;
        pulse_start();
        wait_halt(60, ok, cyc);
        n_tests++; if (!ok || cyc != 5) begin n_fail++; $display("FAIL basic_restart_cycles: got %0d ok=%0d expected 5", cyc, ok); end
        n_tests++; if (ret_cnt != 2) begin n_fail++; $display("FAIL basic_restart_retired: got %0d expected 2", ret_cnt); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_q.size() == 0) begin
                n_fail++; $display("FAIL basic_txn: got none expected addr=%h data=%h", e.addr, e.data);
            end else begin
                g = obs_q.pop_front();
                if (g !== e) begin n_fail++; $display("FAIL basic_txn: got we=%b addr=%h data=%h cyc=%0d st=%b expected we=%b addr=%h data=%h cyc=%0d st=%b", g.we, g.addr, g.data, g.cyc, g.stable, e.we, e.addr, e.data, e.cyc, e.stable); end
            end
        end
        n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL basic_extra_txn: got %0d expected 0", obs_q.size()); end
    endtask

    task automatic test_alu();
        bit ok;
        int cyc;
        txn_t e, g;
        logic [7:0] a, b;
        a = 8'h3C; b = 8'hA5;
        wait_cycles = 0; hold_ack = 1'b0;
        do_reset();
        clear_rom();
        rom[0]  = enci(4'hA, 4'd1, a);
        rom[1]  = enci(4'hA, 4'd2, b);
        rom[2]  = enc(4'h2, 4'd3, 4'd1, 4'd2);
        rom[3]  = enc(4'h3, 4'd4, 4'd1, 4'd2);
        rom[4]  = enc(4'h4, 4'd5, 4'd1, 4'd2);
        rom[5]  = enc(4'h5, 4'd6, 4'd1, 4'd2);
        rom[6]  = enc(4'h1, 4'd7, 4'd2, 4'd2);
        rom[7]  = enc(4'h9, 4'd3, 4'd1, 4'd0);
        rom[8]  = enc(4'h9, 4'd4, 4'd2, 4'd0);
        rom[9]  = enc(4'h9, 4'd5, 4'd1, 4'd2);
        rom[10] = enc(4'h9, 4'd6, 4'd2, 4'd2);
        rom[11] = enc(4'h9, 4'd7, 4'd0, 4'd0);
        rom[12] = 16'hF000;
        exp_q.push_back(mk(1'b1, a, alu_model(4'h2, a, b), 8'd1));
        exp_q.push_back(mk(1'b1, b, alu_model(4'h3, a, b), 8'd1));
        exp_q.push_back(mk(1'b1, alu_model(4'h1, a, b), alu_model(4'h4, a, b), 8'd1));
        exp_q.push_back(mk(1'b1, alu_model(4'h1, b, b), alu_model(4'h5, a, b), 8'd1));
        exp_q.push_back(mk(1'b1, 8'h00, alu_model(4'h1, b, b), 8'd1));
        pulse_start();
        wait_halt(200, ok, cyc);
        n_tests++; if (!ok || cyc != 31) begin n_fail++; $display("FAIL alu_cycles: got %0d ok=%0d expected 31", cyc, ok); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_q.size() == 0) begin
                n_fail++; $display("FAIL alu_txn: got none expected addr=%h data=%h", e.addr, e.data);
            end else begin
                g = obs_q.pop_front();
                if (g !== e) begin n_fail++; $display("FAIL alu_txn: got we=%b addr=%h data=%h cyc=%0d st=%b expected we=%b addr=%h data=%h cyc=%0d st=%b", g.we, g.addr, g.data, g.cyc, g.stable, e.we, e.addr, e.data, e.cyc, e.stable); end
            end
        end
        n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL alu_extra_txn: got %0d expected 0", obs_q.size()); end
    endtask

    task automatic test_rotate();
        bit ok;
        int cyc;
        txn_t e, g;
        wait_cycles = 0; hold_ack = 1'b0;
        do_reset();
        clear_rom();
        rom[0]  = enci(4'hA, 4'd1, 8'h81);
        rom[1]  = enci(4'hA, 4'd2, 8'h01);
        rom[2]  = enc(4'h6, 4'd3, 4'd1, 4'd2);
        rom[3]  = enc(4'h7, 4'd4, 4'd1, 4'd2);
        rom[4]  = enci(4'hA, 4'd2, 8'h09);
        rom[5]  = enc(4'h6, 4'd5, 4'd1, 4'd2);
        rom[6]  = enc(4'h7, 4'd6, 4'd1, 4'd2);
        rom[7]  = enci(4'hA, 4'd9, 8'h20);
        rom[8]  = enc(4'h9, 4'd3, 4'd9, 4'd0);
        rom[9]  = enc(4'h9, 4'd4, 4'd9, 4'd2);
        rom[10] = enc(4'h9, 4'd5, 4'd9, 4'd9);
        rom[11] = enc(4'h9, 4'd6, 4'd0, 4'd9);
        rom[12] = 16'hF000;
        exp_q.push_back(mk(1'b1, 8'h20, alu_model(4'h6, 8'h81, 8'h01), 8'd1));
        exp_q.push_back(mk(1'b1, 8'h29, alu_model(4'h7, 8'h81, 8'h01), 8'd1));
        exp_q.push_back(mk(1'b1, 8'h40, alu_model(4'h6, 8'h81, 8'h09), 8'd1));
        exp_q.push_back(mk(1'b1, 8'h20, alu_model(4'h7, 8'h81, 8'h09), 8'd1));
        pulse_start();
        wait_halt(200, ok, cyc);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL rot_timeout: halted never seen within %0d cycles", cyc); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_q.size() == 0) begin
                n_fail++; $display("FAIL rot_txn: got none expected addr=%h data=%h", e.addr, e.data);
            end else begin
                g = obs_q.pop_front();
                if (g !== e) begin n_fail++; $display("FAIL rot_txn: got we=%b addr=%h data=%h cyc=%0d st=%b expected we=%b addr=%h data=%h cyc=%0d st=%b", g.we, g.addr, g.data, g.cyc, g.stable, e.we, e.addr, e.data, e.cyc, e.stable); end
            end
        end
        n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL rot_extra_txn: got %0d expected 0", obs_q.size()); end
    endtask

    task automatic test_mem_wait();
        bit ok;
        int cyc;
        txn_t e, g;
        wait_cycles = 3; hold_ack = 1'b0;
        do_reset();
        clear_rom();
        rom[0] = enci(4'hA, 4'd5, 8'hAA);
        rom[1] = enci(4'hA, 4'd6, 8'h10);
        rom[2] = enci(4'hA, 4'd7, 8'h02);
        rom[3] = enc(4'h9, 4'd5, 4'd6, 4'd7);
        rom[4] = enc(4'h8, 4'd8, 4'd6, 4'd7);
        rom[5] = enc(4'h9, 4'd8, 4'd0, 4'd0);
        rom[6] = 16'hF000;
        dmem_model[8'h12] = 8'h33;
        exp_q.push_back(mk(1'b1, 8'h12, 8'hAA, 8'd4));
        exp_q.push_back(mk(1'b0, 8'h12, 8'hAA, 8'd4));
        exp_q.push_back(mk(1'b1, 8'h00, 8'hAA, 8'd4));
        pulse_start();
        wait_halt(200, ok, cyc);
        n_tests++; if (!ok || cyc != 26) begin n_fail++; $display("FAIL mem_cycles: got %0d ok=%0d expected 26", cyc, ok); end
        n_tests++; if (ret_cnt != 7) begin n_fail++; $display("FAIL mem_retired: got %0d expected 7", ret_cnt); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_q.size() == 0) begin
                n_fail++; $display("FAIL mem_txn: got none expected addr=%h data=%h", e.addr, e.data);
            end else begin
                g = obs_q.pop_front();
                if (g !== e) begin n_fail++; $display("FAIL mem_txn: got we=%b addr=%h data=%h cyc=%0d st=%b expected we=%b addr=%h data=%h cyc=%0d st=%b", g.we, g.addr, g.data, g.cyc, g.stable, e.we, e.addr, e.data, e.cyc, e.stable); end
            end
        end
        n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL mem_extra_txn: got %0d expected 0", obs_q.size()); end
        wait_cycles = 0;
    endtask

    task automatic test_branch();
        bit ok;
        int cyc;
        logic [7:0] e, g;
        wait_cycles = 0; hold_ack = 1'b0;
        do_reset();
        clear_rom();
        rom[8'h00] = enci(4'hB, 4'd0, 8'h06);
        rom[8'h06] = enci(4'hA, 4'd1, 8'h01);
        rom[8'h07] = enci(4'hB, 4'd1, 8'h20);
        rom[8'h08] = enci(4'hA, 4'd0, 8'h05);
        rom[8'h09] = enci(4'hC, 4'd0, 8'hFF);
        rom[8'hFF] = 16'h0000;
        pc_exp_q = '{8'h06, 8'h07, 8'h08, 8'h09, 8'hFF, 8'h00, 8'h01, 8'h01};
        pulse_start();
        wait_halt(100, ok, cyc);
        n_tests++; if (!ok || cyc != 16) begin n_fail++; $display("FAIL br_cycles: got %0d ok=%0d expected 16", cyc, ok); end
        while (pc_exp_q.size() > 0) begin
            e = pc_exp_q.pop_front();
            n_tests++;
            if (pc_obs_q.size() == 0) begin
                n_fail++; $display("FAIL br_pc: got none expected %h", e);
            end else begin
                g = pc_obs_q.pop_front();
                if (g !== e) begin n_fail++; $display("FAIL br_pc: got %h expected %h", g, e); end
            end
        end
        n_tests++; if (pc_obs_q.size() != 0) begin n_fail++; $display("FAIL br_extra_pc: got %0d expected 0", pc_obs_q.size()); end
    endtask

    task automatic test_reset_mid_mem();
        bit ok;
        int cyc;
        txn_t e, g;
        wait_cycles = 0; hold_ack = 1'b1;
        do_reset();
        clear_rom();
        for (int i = 1; i < 16; i++) rom[i-1] = enci(4'hA, 4'(i), 8'(i));
        rom[15] = enc(4'h9, 4'd1, 4'd0, 4'd0);
        rom[16] = 16'hF000;
        pulse_start();
        cyc = 0;
        while (dmem_req !== 1'b1 && cyc < 100) begin
            @(posedge clk); cyc++; @(negedge clk);
        end
        n_tests++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL rmm_req_timeout: dmem_req got %b expected 1", dmem_req); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_tests++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL rmm_req: got %b expected 0", dmem_req); end
        n_tests++; if (busy !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL rmm_state: busy=%b halted=%b expected 0 0", busy, halted); end
        n_tests++; if (imem_addr !== 8'h00) begin n_fail++; $display("FAIL rmm_pc: got %h expected 00", imem_addr); end
        reset = 1'b0;
        hold_ack = 1'b0;
        repeat (4) @(negedge clk);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmm_needs_start: busy got %b expected 0", busy); end
        obs_q.delete();
        clear_rom();
        for (int i = 1; i < 16; i++) begin
            rom[i-1] = enc(4'h9, 4'(i), 4'd0, 4'd0);
            exp_q.push_back(mk(1'b1, 8'h00, 8'h00, 8'd1));
        end
        pulse_start();
        wait_halt(200, ok, cyc);
        n_tests++; if (!ok || cyc != 47) begin n_fail++; $display("FAIL rmm_cycles: got %0d ok=%0d expected 47", cyc, ok); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_q.size() == 0) begin
                n_fail++; $display("FAIL rmm_reg_zero: got none expected data=%h", e.data);
            end else begin
                g = obs_q.pop_front();
                if (g !== e) begin n_fail++; $display("FAIL rmm_reg_zero: got we=%b addr=%h data=%h cyc=%0d st=%b expected we=%b addr=%h data=%h cyc=%0d st=%b", g.we, g.addr, g.data, g.cyc, g.stable, e.we, e.addr, e.data, e.cyc, e.stable); end
            end
        end
        n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL rmm_extra_txn: got %0d expected 0", obs_q.size()); end
    endtask

    task automatic test_restart_busy();
        bit ok;
        int cyc;
        txn_t e, g;
        logic [7:0] pe, pg;
        wait_cycles = 0; hold_ack = 1'b0;
        do_reset();
        clear_rom();
        rom[0] = enci(4'hA, 4'd1, 8'h11);
        rom[1] = enci(4'hC, 4'd0, 8'h03);
        rom[2] = 16'hF000;
        rom[3] = enc(4'h9, 4'd1, 4'd0, 4'd0);
        rom[4] = 16'hF000;
        for (int run = 0; run < 2; run++) begin
            pc_obs_q.delete();
            pc_exp_q = '{8'h01, 8'h03, 8'h04, 8'h04};
            exp_q.push_back(mk(1'b1, 8'h00, 8'h11, 8'd1));
            pulse_start();
            cyc = 0; ok = 1'b0;
            while (1) begin
                if (halted === 1'b1) begin ok = 1'b1; break; end
                if (cyc >= 60) break;
                // start held high while the core is busy must be ignored
                start = (run == 0) && (cyc >= 1) && (cyc <= 6);
                @(posedge clk); cyc++; @(negedge clk);
            end
            start = 1'b0;
            @(posedge clk); @(negedge clk);
            n_tests++; if (!ok || cyc != 9) begin n_fail++; $display("FAIL rs_cycles run%0d: got %0d ok=%0d expected 9", run, cyc, ok); end
            while (pc_exp_q.size() > 0) begin
                pe = pc_exp_q.pop_front();
                n_tests++;
                if (pc_obs_q.size() == 0) begin
                    n_fail++; $display("FAIL rs_pc run%0d: got none expected %h", run, pe);
                end else begin
                    pg = pc_obs_q.pop_front();
                    if (pg !== pe) begin n_fail++; $display("FAIL rs_pc run%0d: got %h expected %h", run, pg, pe); end
                end
            end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (obs_q.size() == 0) begin
                    n_fail++; $display("FAIL rs_txn run%0d: got none expected data=%h", run, e.data);
                end else begin
                    g = obs_q.pop_front();
                    if (g !== e) begin n_fail++; $display("FAIL rs_txn run%0d: got addr=%h data=%h cyc=%0d expected addr=%h data=%h cyc=%0d", run, g.addr, g.data, g.cyc, e.addr, e.data, e.cyc); end
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) dmem_model[i] = 8'(i) ^ 8'h5A;
        clear_rom();
        test_reset();
        test_basic();
        test_alu();
        test_rotate();
        test_mem_wait();
        test_branch();
        test_reset_mid_mem();
        test_restart_busy();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
